ser_dat_tx: RTL and testbench
=============================

# ser_dat_tx

Bus-mapped serial transmitter: the write-direction counterpart of the serial-data read path on the same SSER/BA window. Host bus writes load a byte, and the block shifts it out MSB-first on `sdo` with a generated `sclk` and a host-controlled `scs_n`. A status register is readable at the same window so firmware can poll `busy` and `overrun`. It sits between the host bus decode and the external serial device.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period. Legal range 1–255.
- `FRAME_BITS`, default 8: bits per frame. Legal range 1–8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sser` in 1: active-low block select.
- `ba` in 10: address bits BA13..BA4, with `ba[9]`=BA13, `ba[8]`=BA12 and `ba[3:0]`=BA7..BA4.
- `br_w` in 1: 1=read, 0=write.
- `bd_in` in 8: write data.
- `bd_out` out 8: read data.
- `bd_oe` out 1: read-data drive enable.
- `scs_n` out 1: serial chip select, active-low.
- `sclk` out 1: serial clock.
- `sdo` out 1: serial data.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- **Window:** `sel = ~sser & ~ba[9] & ba[8]`. The command field is `cmd = ba[3:0]`. Every bus cycle is sampled once per `clk` when `sel` is high.
- **Write commands** (`br_w`=0):
  - `cmd` 0x0 DATA: load `bd_in` and start a frame.
  - `cmd` 0x1 CS_ON: `scs_n` goes to 0.
  - `cmd` 0x2 CS_OFF: `scs_n` goes to 1.
  - Other codes are ignored.
- **Read command** (`br_w`=1, `cmd` 0x0):
  - `bd_out = {6'b0, overrun, busy}` and `bd_oe` = 1.
  - The read clears `overrun` in the same edge.
  - Other read codes give `bd_oe` = 0.
- **FSM states:** IDLE, LOW, HIGH.
  - IDLE + DATA write: shift register loads `bd_in`; bit counter loads `FRAME_BITS`−1; phase counter loads `CLK_DIV`−1; go to LOW.
  - LOW: `sclk`=0 and `sdo`=current bit. When the phase counter reaches 0, go to HIGH and reload the phase counter.
  - HIGH: `sclk`=1. When the phase counter reaches 0:
    - if bit counter = 0: go to IDLE and pulse `done`;
    - otherwise decrement the bit counter, shift, and go to LOW.
- **Writes while not IDLE:** any DATA, CS_ON or CS_OFF write sets sticky `overrun` and changes nothing else. The frame continues unaffected.
- **Write/read ordering:** a status read and an overrun-causing write cannot coincide, because only one bus operation occurs per cycle. A read in the same cycle as a frame end returns `busy`=1.
- **Reset values:** `sclk`=0, `sdo`=0, `scs_n`=1, `bd_out`=0, `bd_oe`=0, `done`=0, `busy`=0, `overrun`=0, FSM=IDLE.
- **Reset mid-frame:** asserting `rst_n` low mid-frame aborts the frame immediately. No `done` pulse is produced.
- **`busy`** = (state ≠ IDLE).

## Timing
- A DATA write sampled at edge N gives:
  - `busy`=1 and `sdo`=bit[FRAME_BITS−1] from edge N+1;
  - first `sclk` rise at edge N+1+`CLK_DIV`.
- Each bit occupies 2·`CLK_DIV` cycles. `sdo` changes only on the edge where `sclk` falls, or on frame start.
- Frame end: `sclk` falls, `busy`=0 and `done`=1 at edge N+1+2·`CLK_DIV`·`FRAME_BITS`. `done` is low at the next edge.
- A new DATA write is accepted on the first cycle after `busy` falls.
- `scs_n` changes on the edge after a CS write, with 1-cycle latency.
- Status reads: `bd_out`/`bd_oe` are registered with 1-cycle latency and are deasserted on the cycle after `sel` drops.

## Configuration
- `SER_DAT_TX_LSB_FIRST_EN`:
  - When defined, frames shift LSB-first: the first `sdo` bit is bit 0 and the shift is rightward.
  - When undefined, frames shift MSB-first (bit `FRAME_BITS`−1 first).
  - Timing is identical in both cases.

## Structure
- Package `ser_dat_tx_pkg` holds:
  - the state enum `tx_state_t` {IDLE, LOW, HIGH};
  - the command constants `CMD_DATA`, `CMD_CS_ON`, `CMD_CS_OFF`, `CMD_STATUS`;
  - the window-match constants `WIN_BA13`=0 and `WIN_BA12`=1.
- Sub-module `ser_dat_tx_phase` is the reloadable down-counter for the half-period. Ports: `clk`, `rst_n`, `load`, `zero`.
- The top level holds the FSM, shift register, bit counter, CS and status logic.

## Test plan
All scenarios use `CLK_DIV`=2 and `FRAME_BITS`=8.
- **Reset:** hold `rst_n`=0 → all outputs at reset values, `scs_n`=1. Release → still idle.
- **CS_ON, DATA 0xA5, CS_OFF:**
  - `sdo` sequence 1,0,1,0,0,1,0,1 is sampled on 8 `sclk` rises.
  - `done` pulses exactly at 33 cycles after the write.
  - `scs_n` is low for the whole frame.
- **Overrun:** a DATA 0x3C write at cycle 5 of a 0xFF frame →
  - the output stays all ones;
  - a status read returns 0x03 while busy;
  - a second read after the frame returns 0x00.
- **Back-to-back:** DATA write in the first cycle after `busy` falls → accepted, with no overrun.
- **Reset mid-frame:** `rst_n` pulse at cycle 10 → `sclk`=0, `busy`=0, no `done`. A subsequent DATA 0x01 frame is correct.
- **`SER_DAT_TX_LSB_FIRST_EN` defined:** DATA 0x01 → first `sdo` bit is 1, then seven 0s.

Source files
------------

// File: rtl/ser_dat_tx_pkg.sv
// ser_dat_tx_pkg: shared types and constants for the bus-mapped serial transmitter.
package ser_dat_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } tx_state_t;

    // Command field (BA7..BA4) codes
    localparam logic [3:0] CMD_DATA   = 4'h0;
    localparam logic [3:0] CMD_CS_ON  = 4'h1;
    localparam logic [3:0] CMD_CS_OFF = 4'h2;
    localparam logic [3:0] CMD_STATUS = 4'h0;

    // Window match values for BA13 / BA12
    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    // Width of a down-counter that must hold values 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ser_dat_tx_phase.sv
// ser_dat_tx_phase: reloadable down-counter timing one sclk half-period.
// zero is high when the current half-period has run its CLK_DIV cycles.
module ser_dat_tx_phase
    import ser_dat_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int unsigned PW = cnt_width(CLK_DIV);

    logic [PW-1:0] cnt;

    // Reload to CLK_DIV-1 on request, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= PW'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - PW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ser_dat_tx.sv
// ser_dat_tx: bus-mapped serial transmitter on the SSER/BA window.
// Bus writes load a frame or drive chip select; a status read returns
// {overrun, busy}. Optional macro SER_DAT_TX_LSB_FIRST_EN shifts frames
// LSB-first instead of MSB-first.
module ser_dat_tx
    import ser_dat_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sser,
    input  logic [9:0] ba,
    input  logic       br_w,
    input  logic [7:0] bd_in,
    output logic [7:0] bd_out,
    output logic       bd_oe,
    output logic       scs_n,
    output logic       sclk,
    output logic       sdo,
    output logic       done
);

    localparam int unsigned BW = cnt_width(FRAME_BITS);

    tx_state_t             state, state_nxt;
    logic                  sel;
    logic [3:0]            cmd;
    logic                  wr_req;
    logic                  rd_stat;
    logic                  wr_vld_q;
    logic [3:0]            wr_cmd_q;
    logic [FRAME_BITS-1:0] wr_data_q;
    logic [FRAME_BITS-1:0] shreg;
    logic [BW-1:0]         bitcnt;
    logic                  phase_zero;
    logic                  phase_load;
    logic                  sh_load;
    logic                  sh_shift;
    logic                  done_nxt;
    logic                  overrun_set;
    logic                  busy;
    logic                  overrun;
    logic                  unused_bits;

    assign sel     = ~sser & (ba[9] == WIN_BA13) & (ba[8] == WIN_BA12);
    assign cmd     = ba[3:0];
    assign wr_req  = sel & ~br_w &
                     ((cmd == CMD_DATA) | (cmd == CMD_CS_ON) | (cmd == CMD_CS_OFF));
    assign rd_stat = sel & br_w & (cmd == CMD_STATUS);
    assign busy    = (state != IDLE);

    // BA7..BA4 carry the command; the remaining window bits are don't-care
    assign unused_bits = ^{ba[7:4], bd_in};

    // Writes are registered once so the FSM acts on them one edge after sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_cmd_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_vld_q <= wr_req;
            if (wr_req) begin
                wr_cmd_q  <= cmd;
                wr_data_q <= bd_in[FRAME_BITS-1:0];
            end
        end
    end

    ser_dat_tx_phase #(
        .CLK_DIV(CLK_DIV)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (phase_load),
        .zero  (phase_zero)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt  = state;
        phase_load = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_vld_q && (wr_cmd_q == CMD_DATA)) begin
                    state_nxt  = LOW;
                    sh_load    = 1'b1;
                    phase_load = 1'b1;
                end
            end
            LOW: begin
                if (phase_zero) begin
                    state_nxt  = HIGH;
                    phase_load = 1'b1;
                end
            end
            HIGH: begin
                if (phase_zero) begin
                    if (bitcnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = LOW;
                        sh_shift   = 1'b1;
                        phase_load = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign overrun_set = wr_vld_q & busy;

    // Shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (sh_load) begin
            shreg  <= wr_data_q;
            bitcnt <= BW'(FRAME_BITS - 1);
        end else if (sh_shift) begin
`ifdef SER_DAT_TX_LSB_FIRST_EN
            shreg  <= shreg >> 1;
`else
            shreg  <= shreg << 1;
`endif
            bitcnt <= bitcnt - BW'(1);
        end
    end

    // Frame-end pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= done_nxt;
        end
    end

    // Chip select follows CS writes accepted while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_n <= 1'b1;
        end else if (wr_vld_q && !busy) begin
            if (wr_cmd_q == CMD_CS_ON) begin
                scs_n <= 1'b0;
            end else if (wr_cmd_q == CMD_CS_OFF) begin
                scs_n <= 1'b1;
            end
        end
    end

    // Status read port and sticky overrun; a set in the same edge as a read wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bd_out  <= '0;
            bd_oe   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            bd_oe  <= rd_stat;
            bd_out <= rd_stat ? {6'b0, overrun, busy} : '0;
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (rd_stat) begin
                overrun <= 1'b0;
            end
        end
    end

    assign sclk = (state == HIGH);
`ifdef SER_DAT_TX_LSB_FIRST_EN
    assign sdo  = busy & shreg[0];
`else
    assign sdo  = busy & shreg[FRAME_BITS-1];
`endif

endmodule

// File: tb/tb_ser_dat_tx.sv
// tb_ser_dat_tx: directed self-checking bench for ser_dat_tx (CLK_DIV=2, FRAME_BITS=8).
module tb_ser_dat_tx;
    import ser_dat_tx_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       sser;
    logic [9:0] ba;
    logic       br_w;
    logic [7:0] bd_in;
    logic [7:0] bd_out;
    logic       bd_oe;
    logic       scs_n;
    logic       sclk;
    logic       sdo;
    logic       done;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Monitor state, reset by clear_mon()
    int          cyc;
    int          nbits;
    logic [15:0] got;
    logic        sclk_prev;
    int          done_cnt;
    int          done_first;
    int          done_last;
    logic        scs_or;

    logic [7:0]  rd_v;
    logic        oe_v;

    ser_dat_tx #(
        .CLK_DIV    (2),
        .FRAME_BITS (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sser   (sser),
        .ba     (ba),
        .br_w   (br_w),
        .bd_in  (bd_in),
        .bd_out (bd_out),
        .bd_oe  (bd_oe),
        .scs_n  (scs_n),
        .sclk   (sclk),
        .sdo    (sdo),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ord(input logic [7:0] d);
        logic [7:0] r;
`ifdef SER_DAT_TX_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_idle();
        sser  = 1'b1;
        br_w  = 1'b1;
        ba    = '0;
        bd_in = '0;
    endtask

    task automatic set_wr(input logic [3:0] c, input logic [7:0] d);
        sser  = 1'b0;
        br_w  = 1'b0;
        ba    = {WIN_BA13, WIN_BA12, 4'h0, c};
        bd_in = d;
    endtask

    task automatic set_rd();
        sser  = 1'b0;
        br_w  = 1'b1;
        ba    = {WIN_BA13, WIN_BA12, 4'h0, CMD_STATUS};
        bd_in = '0;
    endtask

    task automatic clear_mon();
        cyc        = -1;
        nbits      = 0;
        got        = '0;
        sclk_prev  = 1'b0;
        done_cnt   = 0;
        done_first = -1;
        done_last  = -1;
        scs_or     = 1'b0;
    endtask

    // One clock; sample 1 ns after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (sclk && !sclk_prev) begin
            got = {got[14:0], sdo};
            nbits++;
        end
        sclk_prev = sclk;
        if (done) begin
            done_cnt++;
            if (done_first < 0) done_first = cyc;
            done_last = cyc;
        end
        if (cyc >= 1 && cyc <= 33) scs_or = scs_or | scs_n;
    endtask

    task automatic do_read(output logic [7:0] v, output logic oe);
        set_rd();
        cycle();
        v  = bd_out;
        oe = bd_oe;
        set_idle();
    endtask

    initial begin
        // ---------------- Reset ----------------
        rst_n = 1'b0;
        set_idle();
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk",   32'(sclk),   32'h0);
        check("rst_sdo",    32'(sdo),    32'h0);
        check("rst_scs_n",  32'(scs_n),  32'h1);
        check("rst_bd_out", 32'(bd_out), 32'h00);
        check("rst_bd_oe",  32'(bd_oe),  32'h0);
        check("rst_done",   32'(done),   32'h0);
        rst_n = 1'b1;
        repeat (2) cycle();
        check("idle_sclk",  32'(sclk),   32'h0);
        check("idle_scs_n", 32'(scs_n),  32'h1);
        do_read(rd_v, oe_v);
        check("idle_stat",  32'(rd_v),   32'h00);
        check("idle_oe",    32'(oe_v),   32'h1);
        cycle();
        check("oe_drop",    32'(bd_oe),  32'h0);

        // ---------------- CS_ON, DATA 0xA5, CS_OFF ----------------
        set_wr(CMD_CS_ON, 8'h00);
        cycle();
        set_idle();
        cycle();
        check("cs_on", 32'(scs_n), 32'h0);
        clear_mon();
        set_wr(CMD_DATA, 8'hA5);
        cycle();                    // write edge = 0
        set_idle();
        cycle();                    // edge 1
        check("a5_first_sdo",  32'(sdo),  32'(ord(8'hA5) >> 7));
        check("a5_first_sclk", 32'(sclk), 32'h0);
        repeat (34) cycle();        // through edge 35
        check("a5_nbits",   32'(nbits),      32'd8);
        check("a5_bits",    32'(got[7:0]),   32'(ord(8'hA5)));
        check("a5_done_at", 32'(done_first), 32'd33);
        check("a5_done_n",  32'(done_cnt),   32'd1);
        check("a5_cs_low",  32'(scs_or),     32'h0);
        set_wr(CMD_CS_OFF, 8'h00);
        cycle();
        set_idle();
        cycle();
        check("cs_off", 32'(scs_n), 32'h1);

        // ---------------- Overrun ----------------
        clear_mon();
        set_wr(CMD_DATA, 8'hFF);
        cycle();                    // 0
        set_idle();
        repeat (4) cycle();         // 1..4
        set_wr(CMD_DATA, 8'h3C);
        cycle();                    // 5
        set_idle();
        cycle();                    // 6
        do_read(rd_v, oe_v);        // 7
        check("ovr_stat_busy", 32'(rd_v), 32'h03);
        check("ovr_oe",        32'(oe_v), 32'h1);
        cycle();                    // 8
        check("ovr_oe_drop",   32'(bd_oe), 32'h0);
        repeat (27) cycle();        // to 35
        check("ovr_nbits",   32'(nbits),      32'd8);
        check("ovr_bits",    32'(got[7:0]),   32'hFF);
        check("ovr_done_at", 32'(done_first), 32'd33);
        do_read(rd_v, oe_v);
        check("ovr_stat_after", 32'(rd_v), 32'h00);

        // ---------------- Back-to-back ----------------
        clear_mon();
        set_wr(CMD_DATA, 8'h81);
        cycle();                    // 0
        set_idle();
        repeat (33) cycle();        // to 33, busy falls here
        set_wr(CMD_DATA, 8'h5A);
        cycle();                    // 34
        set_idle();
        repeat (34) cycle();        // to 68
        check("b2b_nbits",  32'(nbits),      32'd16);
        check("b2b_bits",   32'(got),        32'({ord(8'h81), ord(8'h5A)}));
        check("b2b_done1",  32'(done_first), 32'd33);
        check("b2b_done2",  32'(done_last),  32'd67);
        check("b2b_done_n", 32'(done_cnt),   32'd2);
        do_read(rd_v, oe_v);
        check("b2b_stat",   32'(rd_v),       32'h00);

        // ---------------- Reset mid-frame ----------------
        clear_mon();
        set_wr(CMD_DATA, 8'hFF);
        cycle();                    // 0
        set_idle();
        repeat (9) cycle();         // 1..9
        rst_n = 1'b0;
        #2;
        check("mid_rst_sclk", 32'(sclk), 32'h0);
        check("mid_rst_sdo",  32'(sdo),  32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        cycle();
        rst_n = 1'b1;
        repeat (30) cycle();
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_sclk",    32'(sclk),     32'h0);
        do_read(rd_v, oe_v);
        check("mid_stat",    32'(rd_v),     32'h00);
        clear_mon();
        set_wr(CMD_DATA, 8'h01);
        cycle();
        set_idle();
        repeat (35) cycle();
        check("post_nbits",   32'(nbits),      32'd8);
        check("post_bits",    32'(got[7:0]),   32'(ord(8'h01)));
        check("post_done_at", 32'(done_first), 32'd33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
